// File: rtl/bitty_pkg.sv
// Shared definitions for the parametrised bitty core.
// Holds the instruction format and ALU opcode encodings, the control FSM state
// encoding and a constant clog2 helper used to size fields from parameters.
package bitty_pkg;

    // Instruction format field, instr[1:0]
    localparam logic [1:0] FMT_RR  = 2'b00;
    localparam logic [1:0] FMT_RI  = 2'b01;
    localparam logic [1:0] FMT_MEM = 2'b10;
    localparam logic [1:0] FMT_ILL = 2'b11;

    // ALU opcode field, instr[4:2]
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    // Control FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_EXEC = 2'd1;
    localparam state_t S_MEM  = 2'd2;
    localparam state_t S_WB   = 2'd3;

    // Ceiling log2, usable in constant expressions
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/bitty_core_p_if.sv
// Instruction handshake and memory bus of the bitty core.
// master: the core (accepts instructions, drives memory requests)
// slave:  the environment (offers instructions, answers memory requests)
//   instr_valid/instr_ready/instr          valid/ready instruction transfer
//   mem_req/mem_we/mem_addr/mem_wdata      request held until mem_ack or abort
//   mem_rdata/mem_ack                      completion and load data
interface bitty_core_p_if #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 16
);
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic               mem_req;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;
    logic               mem_ack;

    modport master (
        input  instr_valid, instr, mem_rdata, mem_ack,
        output instr_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output instr_valid, instr, mem_rdata, mem_ack,
        input  instr_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/bitty_alu_p.sv
// Combinational ALU of the bitty core; all results modulo 2^DATA_W.
//   a, b : operands          op : OP_ADD..OP_CMP
//   y    : result; shifts use the low clog2(DATA_W) bits of b,
//          cmp returns 0 (a==b), 1 (a>b unsigned) or 2 (a<b)
module bitty_alu_p
    import bitty_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] y
);
    localparam int unsigned SH_W = clog2(DATA_W);

    logic [SH_W-1:0] sh;
    assign sh = b[SH_W-1:0];

    always_comb begin
        y = '0;
        case (op)
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_SHL: y = a << sh;
            OP_SHR: y = a >> sh;
            OP_CMP: y = (a == b) ? '0 : ((a > b) ? DATA_W'(1) : DATA_W'(2));
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/bitty_core_p.sv
// Parametrised bitty multi-cycle core: register file, ALU, control FSM and
// memory port. One instruction in flight; IDLE -> EXEC -> (MEM) -> WB -> IDLE.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : master side of the instruction handshake and memory bus
//   d_out      : last result register (reg_c)
//   done / err : one-cycle retire pulse / illegal-or-timeout flag with done
module bitty_core_p
    import bitty_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned NREG        = 8,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    bitty_core_p_if.master    bus,
    output logic [DATA_W-1:0] d_out,
    output logic              done,
    output logic              err
);
    localparam int unsigned RA_W    = clog2(NREG);
    localparam int unsigned INSTR_W = 2 * RA_W + 10;
    localparam int unsigned IMM_W   = RA_W + 5;
    localparam int unsigned CNT_W   = clog2(MEM_TIMEOUT + 1);

    state_t             state;
    state_t             state_n;
    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  regs [NREG];
    logic [DATA_W-1:0]  reg_c;
    logic [CNT_W-1:0]   cnt;
    logic               wb_en;

    // Field decode of the latched instruction; imm overlaps the ry field
    logic [RA_W-1:0]    rx;
    logic [RA_W-1:0]    ry;
    logic [IMM_W-1:0]   imm;
    logic [2:0]         op;
    logic [1:0]         fmt;

    assign rx  = ir[INSTR_W-1 -: RA_W];
    assign ry  = ir[INSTR_W-RA_W-1 -: RA_W];
    assign imm = ir[INSTR_W-RA_W-1:5];
    assign op  = ir[4:2];
    assign fmt = ir[1:0];

    // Register indices beyond NREG only exist for non-power-of-2 NREG.
    // ry is only a register index for register and memory formats.
    logic rx_bad;
    logic ry_bad;
    logic illegal;

    assign rx_bad  = 32'(rx) >= NREG;
    assign ry_bad  = 32'(ry) >= NREG;
    assign illegal = (fmt == FMT_ILL) || rx_bad || ((fmt != FMT_RI) && ry_bad);

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_y;

    assign op_a = regs[rx];
    assign op_b = (fmt == FMT_RI) ? DATA_W'(imm) : regs[ry];

    bitty_alu_p #(.DATA_W(DATA_W)) u_alu (
        .a  (op_a),
        .b  (op_b),
        .op (op),
        .y  (alu_y)
    );

    // Last permitted wait cycle; an ack in this cycle still wins
    logic mem_to;
    assign mem_to = (cnt == CNT_W'(MEM_TIMEOUT - 1));

    assign d_out = reg_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (bus.instr_valid) state_n = S_EXEC;
            S_EXEC: begin
                if (illegal)               state_n = S_WB;
                else if (fmt == FMT_MEM)   state_n = S_MEM;
                else                       state_n = S_WB;
            end
            S_MEM:  if (bus.mem_ack || mem_to) state_n = S_WB;
            S_WB:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath, register file and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            ir              <= '0;
            reg_c           <= '0;
            cnt             <= '0;
            wb_en           <= 1'b0;
            bus.instr_ready <= 1'b1;
            bus.mem_req     <= 1'b0;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            bus.instr_ready <= (state_n == S_IDLE);
            bus.mem_req     <= (state_n == S_MEM);
            done            <= (state_n == S_WB);
            err             <= 1'b0;
            case (state)
                S_IDLE: if (bus.instr_valid) ir <= bus.instr;
                S_EXEC: begin
                    wb_en <= 1'b0;
                    if (illegal) begin
                        err <= 1'b1;
                    end else if (fmt == FMT_MEM) begin
                        cnt           <= '0;
                        bus.mem_we    <= op[0];
                        bus.mem_addr  <= op_b[ADDR_W-1:0];
                        bus.mem_wdata <= op_a;
                    end else begin
                        reg_c <= alu_y;
                        wb_en <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (bus.mem_ack) begin
                        if (!bus.mem_we) begin
                            reg_c <= bus.mem_rdata;
                            wb_en <= 1'b1;
                        end
                        bus.mem_we <= 1'b0;
                    end else if (mem_to) begin
                        err        <= 1'b1;
                        bus.mem_we <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WB: begin
                    if (wb_en) regs[rx] <= reg_c;
                    wb_en <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bitty_core_p.sv
// Directed bench for bitty_core_p: default build (a) and an NREG=6,
// MEM_TIMEOUT=3 build (b). Vectors in a table, plus a reset-in-MEM sequence.
module tb_bitty_core_p;
    import bitty_pkg::*;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        rst_b;
    logic [15:0] dout_a, dout_b;
    logic        done_a, done_b, err_a, err_b;

    always #5 clk = ~clk;

    bitty_core_p_if #(.DATA_W(16), .ADDR_W(8), .INSTR_W(16)) ia ();
    bitty_core_p_if #(.DATA_W(16), .ADDR_W(8), .INSTR_W(16)) ib ();

    bitty_core_p #(.DATA_W(16), .NREG(8), .ADDR_W(8), .MEM_TIMEOUT(255)) dut_a (
        .clk(clk), .reset(rst_a), .bus(ia.master),
        .d_out(dout_a), .done(done_a), .err(err_a)
    );

    bitty_core_p #(.DATA_W(16), .NREG(6), .ADDR_W(8), .MEM_TIMEOUT(3)) dut_b (
        .clk(clk), .reset(rst_b), .bus(ib.master),
        .d_out(dout_b), .done(done_b), .err(err_b)
    );

    int n_vec = 0;
    int miscompares = 0;

    // Memory responder state per build: ack on the ackd-th request cycle (0 = never)
    int          ackd [2];
    logic [15:0] rdat [2];
    int          cnt_a = 0, cnt_b = 0;
    int          len  [2];
    logic [7:0]  cap_addr [2];
    logic        cap_we   [2];
    logic [15:0] cap_wd   [2];
    logic        unstable [2];

    always @(negedge clk) begin
        if (ia.mem_req) begin
            cnt_a = cnt_a + 1;
            if (cnt_a == 1) begin
                cap_addr[0] = ia.mem_addr; cap_we[0] = ia.mem_we; cap_wd[0] = ia.mem_wdata;
            end else if (ia.mem_addr !== cap_addr[0] || ia.mem_we !== cap_we[0] ||
                         ia.mem_wdata !== cap_wd[0]) begin
                unstable[0] = 1'b1;
            end
            len[0]       = cnt_a;
            ia.mem_ack   = (cnt_a == ackd[0]);
            ia.mem_rdata = rdat[0];
        end else begin
            cnt_a      = 0;
            ia.mem_ack = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (ib.mem_req) begin
            cnt_b = cnt_b + 1;
            if (cnt_b == 1) begin
                cap_addr[1] = ib.mem_addr; cap_we[1] = ib.mem_we; cap_wd[1] = ib.mem_wdata;
            end else if (ib.mem_addr !== cap_addr[1] || ib.mem_we !== cap_we[1] ||
                         ib.mem_wdata !== cap_wd[1]) begin
                unstable[1] = 1'b1;
            end
            len[1]       = cnt_b;
            ib.mem_ack   = (cnt_b == ackd[1]);
            ib.mem_rdata = rdat[1];
        end else begin
            cnt_b      = 0;
            ib.mem_ack = 1'b0;
        end
    end

    function automatic logic [15:0] ri(input logic [2:0] rx, input logic [2:0] op,
                                       input logic [7:0] imm);
        return {rx, imm, op, FMT_RI};
    endfunction

    function automatic logic [15:0] rr(input logic [2:0] rx, input logic [2:0] ry,
                                       input logic [2:0] op, input logic [1:0] fmt);
        return {rx, ry, 5'b00000, op, fmt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one instruction (called at a negedge) and wait for its retire pulse
    task automatic run(input bit sel, input logic [15:0] ins, input int ack,
                       input logic [15:0] rd, output logic [15:0] dout, output logic e,
                       output int lat, output logic pulse_ok);
        int k;
        ackd[sel] = ack;
        rdat[sel] = rd;
        k = 0;
        while (!(sel ? ib.instr_ready : ia.instr_ready) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("instr_ready wait", 32'(k < 50), 32'd1);
        if (sel) begin ib.instr = ins; ib.instr_valid = 1'b1; end
        else     begin ia.instr = ins; ia.instr_valid = 1'b1; end
        @(posedge clk);
        #1;
        ia.instr_valid = 1'b0;
        ib.instr_valid = 1'b0;
        lat = 0;
        while (lat < 400) begin
            @(negedge clk);
            lat++;
            if (sel ? done_b : done_a) break;
        end
        check("done wait", 32'(sel ? done_b : done_a), 32'd1);
        dout = sel ? dout_b : dout_a;
        e    = sel ? err_b : err_a;
        @(negedge clk);
        pulse_ok = sel ? (!done_b && !err_b && ib.instr_ready)
                       : (!done_a && !err_a && ia.instr_ready);
    endtask

    typedef struct {
        bit          b;
        logic [15:0] ins;
        int          ack;
        logic [15:0] rd;
        logic [15:0] dout;
        logic        e;
        int          lat;
        int          len;
        logic [7:0]  addr;
        logic        we;
        logic [15:0] wd;
    } vec_t;

    function automatic vec_t alu(input bit b, input logic [15:0] ins,
                                 input logic [15:0] dout, input logic e);
        vec_t v;
        v = '{b, ins, 0, 16'h0, dout, e, 2, 0, 8'h0, 1'b0, 16'h0};
        return v;
    endfunction

    function automatic vec_t mem(input bit b, input logic [15:0] ins, input int ack,
                                 input logic [15:0] rd, input logic [15:0] dout,
                                 input logic e, input int lat, input int len,
                                 input logic [7:0] addr, input logic we, input logic [15:0] wd);
        vec_t v;
        v = '{b, ins, ack, rd, dout, e, lat, len, addr, we, wd};
        return v;
    endfunction

    vec_t        tv [$];
    logic [15:0] got_d;
    logic        got_e;
    int          got_lat;
    logic        got_p;

    initial begin
        ia.instr_valid = 1'b0; ia.instr = '0;
        ib.instr_valid = 1'b0; ib.instr = '0;
        ackd[0] = 0; ackd[1] = 0;
        rdat[0] = '0; rdat[1] = '0;
        unstable[0] = 1'b0; unstable[1] = 1'b0;

        // Build a: NREG=8, MEM_TIMEOUT=255
        tv.push_back(alu(0, ri(1, OP_ADD, 8'd200), 16'd200, 0));
        tv.push_back(alu(0, ri(1, OP_ADD, 8'd100), 16'd300, 0));
        tv.push_back(alu(0, ri(2, OP_SUB, 8'd1),   16'hFFFF, 0));
        tv.push_back(alu(0, ri(2, OP_ADD, 8'd1),   16'h0000, 0));
        tv.push_back(alu(0, ri(1, OP_AND, 8'd0),   16'h0000, 0));
        tv.push_back(alu(0, ri(1, OP_OR,  8'd5),   16'h0005, 0));
        tv.push_back(alu(0, rr(2, 1, OP_CMP, FMT_RR), 16'd2, 0));
        tv.push_back(alu(0, ri(1, OP_SHL, 8'd17),  16'd10, 0));
        tv.push_back(alu(0, rr(1, 2, OP_XOR, FMT_RR), 16'd8, 0));
        tv.push_back(alu(0, rr(1, 2, OP_SHR, FMT_RR), 16'd2, 0));
        tv.push_back(alu(0, rr(2, 1, OP_CMP, FMT_RR), 16'd0, 0));
        tv.push_back(alu(0, rr(1, 2, OP_CMP, FMT_RR), 16'd1, 0));
        tv.push_back(alu(0, ri(3, OP_OR, 8'h20),   16'h0020, 0));
        tv.push_back(mem(0, rr(4, 3, 3'b000, FMT_MEM), 5, 16'hBEEF, 16'hBEEF, 0, 7, 5,
                         8'h20, 1'b0, 16'h0));
        tv.push_back(alu(0, ri(4, OP_OR, 8'h00),   16'hBEEF, 0));
        tv.push_back(mem(0, rr(3, 4, 3'b001, FMT_MEM), 2, 16'h1234, 16'hBEEF, 0, 4, 2,
                         8'hEF, 1'b1, 16'h0020));
        tv.push_back(alu(0, ri(3, OP_OR, 8'h00),   16'h0020, 0));
        tv.push_back(alu(0, rr(3, 4, OP_ADD, FMT_ILL), 16'h0020, 1));
        tv.push_back(alu(0, ri(3, OP_OR, 8'h00),   16'h0020, 0));
        tv.push_back(alu(0, rr(1, 4, OP_ADD, FMT_RR), 16'hBEF0, 0));
        tv.push_back(alu(0, rr(2, 4, OP_SUB, FMT_RR), 16'h4111, 0));
        tv.push_back(alu(0, ri(4, OP_SHR, 8'h24),  16'h0BEE, 0));
        tv.push_back(alu(0, rr(5, 4, OP_CMP, FMT_RR), 16'd2, 0));
        tv.push_back(alu(0, ri(6, OP_OR, 8'hFF),   16'h00FF, 0));
        tv.push_back(alu(0, rr(6, 4, OP_AND, FMT_RR), 16'h00EE, 0));
        tv.push_back(alu(0, ri(0, OP_ADD, 8'hFF),  16'h00FF, 0));
        tv.push_back(alu(0, rr(0, 0, OP_SHL, FMT_RR), 16'h8000, 0));
        tv.push_back(alu(0, rr(0, 0, OP_SHR, FMT_RR), 16'h8000, 0));
        // Build b: NREG=6, MEM_TIMEOUT=3
        tv.push_back(alu(1, ri(1, OP_OR, 8'h55),   16'h0055, 0));
        tv.push_back(mem(1, rr(1, 0, 3'b000, FMT_MEM), 0, 16'h0777, 16'h0055, 1, 5, 3,
                         8'h00, 1'b0, 16'h0));
        tv.push_back(alu(1, ri(1, OP_OR, 8'h00),   16'h0055, 0));
        tv.push_back(mem(1, rr(1, 0, 3'b000, FMT_MEM), 3, 16'h0777, 16'h0777, 0, 5, 3,
                         8'h00, 1'b0, 16'h0));
        tv.push_back(alu(1, ri(1, OP_OR, 8'h00),   16'h0777, 0));
        tv.push_back(alu(1, rr(7, 1, OP_ADD, FMT_RR), 16'h0777, 1));
        tv.push_back(alu(1, rr(1, 6, OP_ADD, FMT_RR), 16'h0777, 1));
        tv.push_back(alu(1, ri(1, OP_OR, 8'h00),   16'h0777, 0));

        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check("reset instr_ready a", 32'(ia.instr_ready), 32'd1);
        check("reset instr_ready b", 32'(ib.instr_ready), 32'd1);
        check("reset d_out a", 32'(dout_a), 32'd0);
        check("reset done/err a", {30'd0, done_a, err_a}, 32'd0);
        check("reset mem_req/we a", {30'd0, ia.mem_req, ia.mem_we}, 32'd0);

        foreach (tv[i]) begin
            run(tv[i].b, tv[i].ins, tv[i].ack, tv[i].rd, got_d, got_e, got_lat, got_p);
            n_vec++;
            check($sformatf("v%0d d_out", i), 32'(got_d), 32'(tv[i].dout));
            check($sformatf("v%0d err", i), 32'(got_e), 32'(tv[i].e));
            check($sformatf("v%0d latency", i), 32'(got_lat), 32'(tv[i].lat));
            check($sformatf("v%0d done pulse/ready", i), 32'(got_p), 32'd1);
            if (tv[i].len > 0) begin
                check($sformatf("v%0d mem_req cycles", i), 32'(len[tv[i].b]), 32'(tv[i].len));
                check($sformatf("v%0d mem_addr", i), 32'(cap_addr[tv[i].b]), 32'(tv[i].addr));
                check($sformatf("v%0d mem_we", i), 32'(cap_we[tv[i].b]), 32'(tv[i].we));
                if (tv[i].we)
                    check($sformatf("v%0d mem_wdata", i), 32'(cap_wd[tv[i].b]), 32'(tv[i].wd));
            end
        end
        check("mem bus stable a", 32'(unstable[0]), 32'd0);
        check("mem bus stable b", 32'(unstable[1]), 32'd0);

        // Reset while a load waits in MEM on build a
        ackd[0] = 0;
        ia.instr = rr(4, 3, 3'b000, FMT_MEM);
        ia.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        ia.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        check("mem_req before reset", 32'(ia.mem_req), 32'd1);
        rst_a = 1'b1;
        @(negedge clk);
        check("mem_req after reset", 32'(ia.mem_req), 32'd0);
        check("done/err during reset", {30'd0, done_a, err_a}, 32'd0);
        rst_a = 1'b0;
        @(negedge clk);
        check("instr_ready after reset", 32'(ia.instr_ready), 32'd1);
        check("d_out after reset", 32'(dout_a), 32'd0);
        for (int r = 0; r < 8; r += 3) begin
            run(0, ri(3'(r + 1), OP_OR, 8'h00), 0, 16'h0, got_d, got_e, got_lat, got_p);
            n_vec++;
            check($sformatf("R%0d cleared by reset", r + 1), 32'(got_d), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end
endmodule
